// File: rtl/clk_enable_gen.sv
// clk_enable_gen: runtime-programmable fractional clock-enable generator.
//
// Produces NUM_CH independent clock-enable strobes, each at f_clk * m / d, from
// one system clock. Each channel has its own lock indicator, and a global sync
// strobe re-aligns the phase of every running channel.
//
// Optional feature macro: CLKGEN_TOGGLE_EN adds clk_tgl[NUM_CH], a square wave
// that toggles on every enable pulse.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   cfg_valid   configuration request
//   cfg_ready   configuration accept (low for one cycle after each transfer)
//   cfg_ch      target channel
//   cfg_enable  1 = enable with ratio cfg_mul/cfg_div, 0 = disable
//   cfg_mul     numerator m
//   cfg_div     denominator d
//   cfg_err     one-cycle pulse after an invalid accepted request
//   sync        global phase-align strobe
//   clk_en      per-channel enable strobe (registered)
//   locked      per-channel lock indicator (registered)
//   clk_tgl     per-channel toggle output (only with CLKGEN_TOGGLE_EN)

module clk_enable_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned W           = 16,
  parameter int unsigned LOCK_PULSES = 4,
  localparam int unsigned CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CW-1:0]     cfg_ch,
  input  logic              cfg_enable,
  input  logic [W-1:0]      cfg_mul,
  input  logic [W-1:0]      cfg_div,
  output logic              cfg_err,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] locked
`ifdef CLKGEN_TOGGLE_EN
  ,
  output logic [NUM_CH-1:0] clk_tgl
`endif
);

  typedef enum logic [1:0] {StDisabled, StLocking, StLocked} ch_state_e;

  localparam logic [7:0] CntMax = 8'(LOCK_PULSES);

  ch_state_e          r_state [NUM_CH];
  logic [W-1:0]       r_m     [NUM_CH];
  logic [W-1:0]       r_d     [NUM_CH];
  logic [W:0]         r_acc   [NUM_CH];
  logic [7:0]         r_cnt   [NUM_CH];
  logic [NUM_CH-1:0]  r_clk_en;
  logic [NUM_CH-1:0]  r_locked;
  logic               r_ready;
  logic               r_err;
`ifdef CLKGEN_TOGGLE_EN
  logic [NUM_CH-1:0]  r_tgl;
`endif

  logic               w_accept;
  logic               w_ch_ok;
  logic               w_ratio_ok;
  logic               w_req_ok;
  logic [W:0]         w_sum   [NUM_CH];
  logic [NUM_CH-1:0]  w_hit;
  logic [NUM_CH-1:0]  w_tgt;

  assign w_accept   = cfg_valid && r_ready;
  assign w_ch_ok    = 32'(cfg_ch) < NUM_CH;
  assign w_ratio_ok = (cfg_mul != '0) && (cfg_div != '0) && (cfg_mul <= cfg_div);
  // A disable request only needs a legal channel number.
  assign w_req_ok   = w_ch_ok && (!cfg_enable || w_ratio_ok);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // acc < d and m <= d, so the sum always fits in W+1 bits.
      w_sum[i] = r_acc[i] + {1'b0, r_m[i]};
      w_hit[i] = w_sum[i] >= {1'b0, r_d[i]};
      w_tgt[i] = w_accept && w_ch_ok && (32'(cfg_ch) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b1;
      r_err    <= 1'b0;
      r_clk_en <= '0;
      r_locked <= '0;
`ifdef CLKGEN_TOGGLE_EN
      r_tgl    <= '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= StDisabled;
        r_m[i]     <= '0;
        r_d[i]     <= '0;
        r_acc[i]   <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_ready <= !w_accept;
      r_err   <= w_accept && !w_req_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_tgt[i]) begin
          // Any accepted request restarts the channel from a clean phase.
          r_clk_en[i] <= 1'b0;
          r_locked[i] <= 1'b0;
          r_acc[i]    <= '0;
          r_cnt[i]    <= '0;
`ifdef CLKGEN_TOGGLE_EN
          r_tgl[i]    <= 1'b0;
`endif
          if (cfg_enable && w_ratio_ok) begin
            r_state[i] <= StLocking;
            r_m[i]     <= cfg_mul;
            r_d[i]     <= cfg_div;
          end else begin
            r_state[i] <= StDisabled;
          end
        end else if (r_state[i] != StDisabled) begin
          // Count the pulse that was visible during the cycle now ending.
          if (r_clk_en[i] && (r_cnt[i] != CntMax)) begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
            if (r_cnt[i] == CntMax - 8'd1) begin
              r_state[i]  <= StLocked;
              r_locked[i] <= 1'b1;
            end
          end
          if (sync) begin
            // Phase re-align: drop any pulse due on this edge.
            r_acc[i]    <= '0;
            r_clk_en[i] <= 1'b0;
          end else begin
            r_acc[i]    <= w_hit[i] ? (w_sum[i] - {1'b0, r_d[i]}) : w_sum[i];
            r_clk_en[i] <= w_hit[i];
`ifdef CLKGEN_TOGGLE_EN
            r_tgl[i]    <= r_tgl[i] ^ r_clk_en[i];
`endif
          end
        end
      end
    end
  end

  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;
  assign clk_en    = r_clk_en;
  assign locked    = r_locked;
`ifdef CLKGEN_TOGGLE_EN
  assign clk_tgl   = r_tgl;
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed scenarios plus a random phase,
// all compared every cycle against an arithmetic reference model.
module tb_clk_enable_gen;
  localparam int NCH = 5;
  localparam int LP  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [2:0]     cfg_ch = '0;
  logic           cfg_enable = 1'b0;
  logic [15:0]    cfg_mul = '0;
  logic [15:0]    cfg_div = '0;
  logic           cfg_err;
  logic           sync = 1'b0;
  logic [NCH-1:0] clk_en;
  logic [NCH-1:0] locked;
`ifdef CLKGEN_TOGGLE_EN
  logic [NCH-1:0] clk_tgl;
`endif

  clk_enable_gen #(.NUM_CH(NCH), .W(16), .LOCK_PULSES(LP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_enable(cfg_enable),
    .cfg_mul   (cfg_mul),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .sync      (sync),
    .clk_en    (clk_en),
    .locked    (locked)
`ifdef CLKGEN_TOGGLE_EN
    ,
    .clk_tgl   (clk_tgl)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: channel n cycles after its phase origin pulses iff
  // floor(n*m/d) advances; locked once LP pulses have completed.
  bit    m_act [NCH];
  longint m_m  [NCH];
  longint m_d  [NCH];
  longint m_n  [NCH];
  int    m_pul [NCH];
  bit    m_en  [NCH];
  bit    m_lk  [NCH];
  bit    m_tg  [NCH];
  bit    m_ready = 1'b1;
  bit    m_err = 1'b0;
  bit    last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit acc, ch_ok, ok, prev;
    if (rst) begin
      m_ready = 1'b1; m_err = 1'b0; last_acc = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_act[c] = 0; m_en[c] = 0; m_lk[c] = 0; m_tg[c] = 0; m_pul[c] = 0; m_n[c] = 0;
      end
      return;
    end
    acc   = cfg_valid && m_ready;
    ch_ok = int'(cfg_ch) < NCH;
    ok    = ch_ok && (!cfg_enable || (cfg_mul != 0 && cfg_div != 0 && cfg_mul <= cfg_div));
    m_err = acc && !ok;
    m_ready = !acc;
    last_acc = acc;
    for (int c = 0; c < NCH; c++) begin
      prev = m_en[c];
      if (acc && ch_ok && int'(cfg_ch) == c) begin
        m_en[c] = 0; m_lk[c] = 0; m_tg[c] = 0; m_pul[c] = 0; m_n[c] = 0;
        m_act[c] = cfg_enable && ok;
        m_m[c] = longint'(cfg_mul);
        m_d[c] = longint'(cfg_div);
      end else if (m_act[c]) begin
        if (prev) m_pul[c]++;
        if (m_pul[c] >= LP) m_lk[c] = 1;
        if (sync) begin
          m_n[c] = 0; m_en[c] = 0;
        end else begin
          m_n[c]++;
          m_en[c] = (m_n[c] * m_m[c]) / m_d[c] > ((m_n[c] - 1) * m_m[c]) / m_d[c];
          m_tg[c] = m_tg[c] ^ prev;
        end
      end
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] e_en, e_lk, e_tg;
    for (int c = 0; c < NCH; c++) begin
      e_en[c] = m_en[c]; e_lk[c] = m_lk[c]; e_tg[c] = m_tg[c];
    end
    check("clk_en", 32'(clk_en), 32'(e_en));
    check("locked", 32'(locked), 32'(e_lk));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef CLKGEN_TOGGLE_EN
    check("clk_tgl", 32'(clk_tgl), 32'(e_tg));
`else
    e_tg = '0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send(input int ch, input bit en, input int m, input int d);
    int tries = 0;
    cfg_ch = 3'(ch); cfg_enable = en; cfg_mul = 16'(m); cfg_div = 16'(d);
    cfg_valid = 1'b1;
    do begin
      step();
      tries++;
    end while (!last_acc && tries < 4);
    cfg_valid = 1'b0;
    check("send_accepted", 32'(last_acc), 32'd1);
  endtask

  initial begin
    int cnt, last_p, gmin, gmax, ones;
    bit pending;

    // Reset
    rst = 1'b1;
    step(); step();
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_clk_en", 32'(clk_en), 32'd0);
    rst = 1'b0;
    step();

    // ch0 1/4: pulses at 4,8,12,16, locked at 17
    send(0, 1, 1, 4);
    check("ch0_ready_low", 32'(cfg_ready), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k % 4 == 0) check("ch0_pulse", 32'(clk_en[0]), 32'd1);
      if (k == 16) check("ch0_not_locked16", 32'(locked[0]), 32'd0);
      if (k == 17) check("ch0_locked17", 32'(locked[0]), 32'd1);
    end
    check("others_idle", 32'(clk_en[4:1]), 32'd0);

    // ch1 3/8 over 800 cycles: 300 pulses, gaps 2..3
    send(1, 1, 3, 8);
    cnt = 0; last_p = 0; gmin = 1000; gmax = 0;
    for (int k = 1; k <= 800; k++) begin
      step();
      if (clk_en[1]) begin
        if (cnt > 0) begin
          if (k - last_p < gmin) gmin = k - last_p;
          if (k - last_p > gmax) gmax = k - last_p;
        end
        cnt++; last_p = k;
      end
    end
    check("ch1_count", 32'(cnt), 32'd300);
    check("ch1_gap_min", 32'(gmin), 32'd2);
    check("ch1_gap_max", 32'(gmax), 32'd3);

    // ch2 5/5: constant 1, locked at 5
    send(2, 1, 5, 5);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("ch2_const", 32'(clk_en[2]), 32'd1);
      if (k == 4) check("ch2_not_locked4", 32'(locked[2]), 32'd0);
      if (k == 5) check("ch2_locked5", 32'(locked[2]), 32'd1);
    end

    // Invalid requests
    send(3, 1, 5, 3);
    check("err_m_gt_d", 32'(cfg_err), 32'd1);
    step();
    check("err_one_cycle", 32'(cfg_err), 32'd0);
    send(3, 1, 0, 4);
    check("err_m_zero", 32'(cfg_err), 32'd1);
    step();
    send(NCH, 1, 1, 2);
    check("err_bad_ch", 32'(cfg_err), 32'd1);
    for (int k = 0; k < 6; k++) step();
    check("ch3_idle", 32'({clk_en[3], locked[3]}), 32'd0);

    // sync with ch0 1/4 and ch1 1/3 locked
    send(1, 1, 1, 3);
    for (int k = 0; k < 20; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_suppress", 32'(clk_en[2:0]), 32'd0);
    check("sync_locked", 32'(locked[1:0]), 32'd3);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("sync_ch0", 32'(clk_en[0]), 32'(k == 4));
      check("sync_ch1", 32'(clk_en[1]), 32'(k == 3));
    end

    // Same-edge cfg on ch1 with sync
    cfg_ch = 3'd1; cfg_enable = 1'b1; cfg_mul = 16'd1; cfg_div = 16'd3;
    cfg_valid = 1'b1; sync = 1'b1;
    step();
    cfg_valid = 1'b0; sync = 1'b0;
    check("same_edge_acc", 32'(last_acc), 32'd1);
    check("same_edge_locked", 32'(locked[1:0]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("se_ch0", 32'(clk_en[0]), 32'(k == 4));
      check("se_ch1", 32'(clk_en[1]), 32'(k == 3));
    end

`ifdef CLKGEN_TOGGLE_EN
    send(0, 1, 1, 2);
    ones = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      ones += int'(clk_tgl[0]);
      if (k == 3) check("tgl_high3", 32'(clk_tgl[0]), 32'd1);
      if (k == 5) check("tgl_low5", 32'(clk_tgl[0]), 32'd0);
    end
    check("tgl_duty", 32'(ones), 32'd4);
`else
    ones = 0;
`endif

    // Random phase
    pending = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      if (!pending && $urandom_range(0, 5) == 0) begin
        int d, m;
        d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
        m = int'($urandom_range(0, d + 1));
        cfg_ch = 3'($urandom_range(0, 7));
        cfg_enable = ($urandom_range(0, 4) != 0);
        cfg_mul = 16'(m); cfg_div = 16'(d);
        cfg_valid = 1'b1; pending = 1'b1;
      end
      sync = ($urandom_range(0, 22) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      step();
      if (last_acc) begin
        pending = 1'b0; cfg_valid = 1'b0;
      end
    end
    sync = 1'b0; rst = 1'b0; cfg_valid = 1'b0;

    // Reset mid-run
    send(0, 1, 1, 1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_clk_en", 32'(clk_en), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_ready", 32'(cfg_ready), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
